gate_net_eval_arbiter: RTL
==========================

// Module: gate_net_eval_arbiter
// PURPOSE
//  Shares one generated MTNCL gate-network instance (in_bits/out_bits, combinational)
//  among N_REQ requesters. Round-robin grant, registered network input drive, fixed settle
//  window, output capture, per-requester response handshake. Sits between the request
//  sources and a single *_mtncl network module, so a large network is not replicated.
// PARAMETERS
//  N_REQ       4  number of requesters (>=2)
//  IN_W        2  network input width (in_bits)
//  OUT_W       2  network output width (out_bits)
//  SETTLE_CYC  2  cycles net_in is held before net_out is sampled (>=1)
// PORTS
//  clk        in   1            single clock; all state on rising edge
//  rst        in   1            synchronous, active-high reset
//  req_valid  in   N_REQ        per-requester request valid
//  req_ready  out  N_REQ        one-hot accept strobe (combinational, IDLE only)
//  req_data   in   N_REQ*IN_W   requester i input vector at [i*IN_W +: IN_W]
//  rsp_valid  out  N_REQ        one-hot response valid to granted requester
//  rsp_ready  in   N_REQ        per-requester response accept
//  rsp_data   out  OUT_W        captured network output (shared bus)
//  net_in     out  IN_W         registered drive to network in_bits
//  net_out    in   OUT_W        network out_bits
//  busy       out  1            high in every state except IDLE
//  null_err   out  1            sticky NULL-check failure (0 when feature compiled out)
// BEHAVIOUR
//  Reset (clk edge with rst=1): state=IDLE, net_in=0, rsp_data=0, rsp_valid=0,
//   busy=0, null_err=0, rr pointer=0 (requester 0 highest priority). Reset mid-op aborts
//   any transaction; a pending response is dropped, not replayed.
//  FSM: IDLE -> EVAL -> RESP -> [NULL] -> IDLE.
//  IDLE: winner g = first i with req_valid[i] searching ptr, ptr+1, ... mod N_REQ.
//   req_ready[g]=1 that cycle only (0 for all if none valid); on transfer:
//   net_in<=req_data[g], grant latched, ptr<=(g+1) mod N_REQ, cnt<=SETTLE_CYC-1, ->EVAL.
//  EVAL: net_in held; cnt decrements; when cnt==0: rsp_data<=net_out, ->RESP.
//  RESP: rsp_valid[g]=1, rsp_data stable, until rsp_ready[g]; on that edge
//   rsp_valid->0, leave RESP. rsp_ready of non-granted requesters ignored.
//  Latency: accept at cycle t -> rsp_valid high from cycle t+SETTLE_CYC+1.
//  Throughput without spacer: one request per SETTLE_CYC+2 cycles min (with
//   zero-wait rsp_ready); no request accepted while busy.
//  req_valid dropping while not granted is legal; no grant is reserved.
//  All counters SETTLE_CYC-sized ($clog2, min 1 bit); ptr wraps N_REQ-1 -> 0.
// CONFIGURATION
//  GNET_NULL_SPACER_EN defined: after RESP, state NULL drives net_in=0 (MTNCL NULL
//   wavefront) for SETTLE_CYC cycles; on last NULL cycle, if net_out!=0 set null_err=1
//   (sticky until rst). Then IDLE. Throughput min 2*SETTLE_CYC+2 cycles/request.
//  Not defined: RESP -> IDLE directly; net_in keeps last DATA value; null_err tied 0.
// TESTING  (N_REQ=4, SETTLE_CYC=2, stub net_out={a^b, a&b} for net_in={b,a})
//  1 Single req: req_valid=4'b0001, req_data[1:0]=2'b01 -> req_ready[0] same cycle,
//    rsp_valid[0] 3 cycles later, rsp_data=2'b10; hold rsp_ready=0 5 cyc -> stays stable.
//  2 Round robin: all 4 req_valid held high -> grant order 0,1,2,3,0; inputs 11 -> 01.
//  3 Wrap/priority: after grant 3, only req 2 and 0 valid -> req 0 granted next.
//  4 Reset mid-EVAL: rst=1 at cycle 1 of EVAL -> next cycle busy=0, net_in=0,
//    rsp_valid=0, next grant goes to req 0.
//  5 Spacer (GNET_NULL_SPACER_EN): normal stub -> net_in=0 for 2 cycles after RESP,
//    null_err=0; stub forcing net_out=2'b01 in NULL -> null_err=1, held until rst.
//  6 Back-to-back (no spacer): req0 continuously valid, rsp_ready=1 -> accepts every
//    4 cycles; req_ready never asserted while busy=1.

Source files
------------

// File: rtl/gate_net_eval_arbiter.sv
// gate_net_eval_arbiter
// Time-shares one combinational MTNCL gate network among N_REQ requesters.
// Requesters are served round-robin. The chosen requester's input vector drives
// net_in from a register. The network output is captured after a fixed settle
// window and returned to that requester through a valid/ready handshake.
// Optional feature macro: GNET_NULL_SPACER_EN. When defined, a NULL wavefront
// (net_in = 0) is inserted after every response, and a non-NULL network output
// on the last spacer cycle sets the sticky null_err flag.
module gate_net_eval_arbiter #(
  parameter int N_REQ      = 4,
  parameter int IN_W       = 2,
  parameter int OUT_W      = 2,
  parameter int SETTLE_CYC = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*IN_W-1:0]   req_data,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [OUT_W-1:0]        rsp_data,
  output logic [IN_W-1:0]         net_in,
  input  logic [OUT_W-1:0]        net_out,
  output logic                    busy,
  output logic                    null_err
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EVAL = 2'd1,
    S_RESP = 2'd2,
    S_NULL = 2'd3
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [PTR_W-1:0]   r_grant;
  logic [CNT_W-1:0]   r_cnt;
  logic [IN_W-1:0]    r_net_in;
  logic [OUT_W-1:0]   r_rsp_data;
  logic [N_REQ-1:0]   r_rsp_valid;

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_next_ptr;

  // Round-robin search starting at the priority pointer; first valid requester wins
  always_comb begin : p_winner
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_win   = PTR_W'(idx);
      end
    end
  end

  assign w_next_ptr = (w_win == PTR_LAST) ? '0 : w_win + 1'b1;

  // Accept strobe is offered only while idle, to the round-robin winner
  always_comb begin
    req_ready = '0;
    if (r_state == S_IDLE && w_found) begin
      req_ready[w_win] = 1'b1;
    end
  end

`ifdef GNET_NULL_SPACER_EN
  logic r_null_err;
`endif

  // Main control FSM: accept, settle, capture, respond (optionally NULL spacer)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      r_net_in    <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= '0;
`ifdef GNET_NULL_SPACER_EN
      r_null_err  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_net_in <= req_data[int'(w_win)*IN_W +: IN_W];
            r_grant  <= w_win;
            r_ptr    <= w_next_ptr;
            r_cnt    <= CNT_LOAD;
            r_state  <= S_EVAL;
          end
        end
        S_EVAL: begin
          if (r_cnt == '0) begin
            r_rsp_data  <= net_out;
            r_rsp_valid <= N_REQ'(1) << r_grant;
            r_state     <= S_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready[r_grant]) begin
            r_rsp_valid <= '0;
`ifdef GNET_NULL_SPACER_EN
            r_net_in    <= '0;
            r_cnt       <= CNT_LOAD;
            r_state     <= S_NULL;
`else
            r_state     <= S_IDLE;
`endif
          end
        end
        S_NULL: begin
`ifdef GNET_NULL_SPACER_EN
          if (r_cnt == '0) begin
            if (net_out != '0) begin
              r_null_err <= 1'b1;
            end
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
`else
          r_state <= S_IDLE;
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign net_in    = r_net_in;
  assign rsp_data  = r_rsp_data;
  assign rsp_valid = r_rsp_valid;
  assign busy      = (r_state != S_IDLE);

`ifdef GNET_NULL_SPACER_EN
  assign null_err = r_null_err;
`else
  assign null_err = 1'b0;
`endif

endmodule
